// File: rtl/booth_mul_arbiter.sv
// Round-robin front end for one shared 8x8 Booth multiplier.
// Latches the winner's operands, times the product and returns it.
module booth_mul_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned START_CYCLES = 1,
  parameter int unsigned MULT_LATENCY = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_m1,
  input  logic [8*NUM_REQ-1:0] req_m2,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 busy,
  output logic                 mul_start,
  output logic [7:0]           mul_m1,
  output logic [7:0]           mul_m2,
  input  logic [15:0]          mul_out
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int CMAX = (START_CYCLES > MULT_LATENCY) ?
                        START_CYCLES : MULT_LATENCY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_WAIT, S_DONE
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      grant_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [15:0]        rsp_data_q;
  logic               busy_q;
  logic               mul_start_q;
  logic [7:0]         mul_m1_q;
  logic [7:0]         mul_m2_q;

  logic               win_vld_d;
  logic [IW-1:0]      win_idx_d;
  logic [IW-1:0]      ptr_d;
  logic [7:0]         win_m1_d;
  logic [7:0]         win_m2_d;
  int unsigned        slot;

  // Scan downward so the slot nearest the pointer is assigned last and wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    slot      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      slot = int'(ptr_q) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (req[slot[IW-1:0]]) begin
        win_vld_d = 1'b1;
        win_idx_d = slot[IW-1:0];
      end
    end
    win_m1_d = '0;
    win_m2_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx_d == IW'(k)) begin
        win_m1_d = req_m1[8*k +: 8];
        win_m2_d = req_m2[8*k +: 8];
      end
    end
    ptr_d = (win_idx_d == IW'(NUM_REQ - 1)) ?
            '0 : win_idx_d + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_m1_q    <= '0;
      mul_m2_q    <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            mul_m1_q    <= win_m1_d;
            mul_m2_q    <= win_m2_d;
            grant_q     <= win_idx_d;
            ack_q       <= ONE << win_idx_d;
            busy_q      <= 1'b1;
            mul_start_q <= 1'b1;
            cnt_q       <= CW'(START_CYCLES - 1);
            ptr_q       <= ptr_d;
            state_q     <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            mul_start_q <= 1'b0;
            cnt_q       <= CW'(MULT_LATENCY - 1);
            state_q     <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= mul_out;
            rsp_valid_q <= ONE << grant_q;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_m1    = mul_m1_q;
  assign mul_m2    = mul_m2_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: default build plus a
// 2-requester, 3-cycle-start, 1-cycle-latency build.
module tb_booth_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic [3:0]  req, ack, rsp_valid;
  logic [31:0] req_m1, req_m2;
  logic [15:0] rsp_data, mul_out;
  logic        busy, mul_start;
  logic [7:0]  mul_m1, mul_m2;

  logic [1:0]  b_req, b_ack, b_rsp_valid;
  logic [15:0] b_m1, b_m2;
  logic [15:0] b_rsp_data, b_mul_out;
  logic        b_busy, b_mul_start;
  logic [7:0]  b_mul_m1, b_mul_m2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] prod(input logic [7:0] a,
                                       input logic [7:0] b);
    logic signed [15:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  assign mul_out   = prod(mul_m1, mul_m2);
  assign b_mul_out = prod(b_mul_m1, b_mul_m2);

  booth_mul_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_m1(req_m1), .req_m2(req_m2),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .mul_start(mul_start),
    .mul_m1(mul_m1), .mul_m2(mul_m2), .mul_out(mul_out)
  );

  booth_mul_arbiter #(
    .NUM_REQ(2), .START_CYCLES(3), .MULT_LATENCY(1)
  ) dut_b (
    .clk(clk), .rst_n(rst2_n),
    .req(b_req), .req_m1(b_m1), .req_m2(b_m2),
    .ack(b_ack), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .busy(b_busy), .mul_start(b_mul_start),
    .mul_m1(b_mul_m1), .mul_m2(b_mul_m2), .mul_out(b_mul_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (ack == 4'b0 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_rsp(output int n, output logic [3:0] seen);
    n = 0;
    seen = '0;
    while (rsp_valid == 4'b0 && n < 40) begin
      step();
      n++;
      seen |= ack;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    req = '0; req_m1 = '0; req_m2 = '0;
    b_req = '0; b_m1 = '0; b_m2 = '0;
    #12;
    total++;
    if ({ack, rsp_valid, rsp_data, busy, mul_start, mul_m1, mul_m2} !== '0) begin
      bad++;
      $display("FAIL reset_out: got %h want 0",
               {ack, rsp_valid, rsp_data, busy, mul_start, mul_m1, mul_m2});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    total++;
    if ({busy, ack} !== 5'b0) begin
      bad++;
      $display("FAIL idle_noreq: got busy/ack %b want 0", {busy, ack});
    end
  endtask

  task automatic test_single();
    int n;
    logic [3:0] seen;
    req = 4'b0001; req_m1[7:0] = 8'h04; req_m2[7:0] = 8'h04;
    step();
    total++;
    if ({ack, mul_start, busy, mul_m1} !== {4'b0001, 1'b1, 1'b1, 8'h04}) begin
      bad++;
      $display("FAIL single_accept: got %b %b %b %h want 0001 1 1 04",
               ack, mul_start, busy, mul_m1);
    end
    req = 4'b0;
    step();
    total++;
    if ({ack, mul_start} !== 5'b0) begin
      bad++;
      $display("FAIL single_start_len: got ack %b start %b want 0 0",
               ack, mul_start);
    end
    wait_rsp(n, seen);
    total++;
    if (n + 1 != 11 || rsp_valid !== 4'b0001 || rsp_data !== 16'h0010
        || busy !== 1'b1 || seen !== 4'b0) begin
      bad++;
      $display("FAIL single_rsp: got edges %0d v %b d %h busy %b want 11 0001 0010 1",
               n + 1, rsp_valid, rsp_data, busy);
    end
    step();
    total++;
    if ({rsp_valid, busy} !== 5'b0) begin
      bad++;
      $display("FAIL single_done: got v %b busy %b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_signed();
    int n;
    logic stable;
    req = 4'b0100; req_m1[23:16] = 8'hFD; req_m2[23:16] = 8'h05;
    step();
    total++;
    if (ack !== 4'b0100) begin
      bad++;
      $display("FAIL signed_ack: got %b want 0100", ack);
    end
    req = 4'b0; req_m1 = 32'hAAAA_AAAA; req_m2 = 32'h5555_5555;
    n = 0;
    stable = 1'b1;
    while (rsp_valid == 4'b0 && n < 40) begin
      if (mul_m1 !== 8'hFD || mul_m2 !== 8'h05) stable = 1'b0;
      step();
      n++;
    end
    total++;
    if (!stable || n != 11 || rsp_valid !== 4'b0100 || rsp_data !== 16'hFFF1) begin
      bad++;
      $display("FAIL signed_rsp: got stable %b edges %0d v %b d %h want 1 11 0100 fff1",
               stable, n, rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_contention();
    int n, last;
    int i;
    logic [3:0] seen;
    logic [15:0] exp_p[4];
    exp_p[0] = 16'h0006; exp_p[1] = 16'h000C;
    exp_p[2] = 16'h0014; exp_p[3] = 16'h001E;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_m1 = 32'h0504_0302;
    req_m2 = 32'h0605_0403;
    req = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      i = k % 4;
      wait_ack(n);
      total++;
      if (ack !== 4'(1 << i)) begin
        bad++;
        $display("FAIL contend_order%0d: got %b want %b", k, ack, 4'(1 << i));
      end
      if (k > 0) begin
        total++;
        if (cyc - last != 13) begin
          bad++;
          $display("FAIL contend_space%0d: got %0d want 13", k, cyc - last);
        end
      end
      last = cyc;
      wait_rsp(n, seen);
      total++;
      if (rsp_valid !== 4'(1 << i) || rsp_data !== exp_p[i] || seen !== 4'b0) begin
        bad++;
        $display("FAIL contend_rsp%0d: got v %b d %h acks %b want %b %h 0000",
                 k, rsp_valid, rsp_data, seen, 4'(1 << i), exp_p[i]);
      end
    end
  endtask

  task automatic test_withdraw();
    int n;
    logic [3:0] seen;
    req = 4'b1001; req_m1[31:24] = 8'h07; req_m2[31:24] = 8'hFF;
    wait_ack(n);
    total++;
    if (ack !== 4'b1000) begin
      bad++;
      $display("FAIL wd_first: got %b want 1000", ack);
    end
    req = 4'b0011;
    step();
    req = 4'b0001;
    wait_rsp(n, seen);
    total++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 16'hFFF9 || seen !== 4'b0) begin
      bad++;
      $display("FAIL wd_rsp: got v %b d %h acks %b want 1000 fff9 0000",
               rsp_valid, rsp_data, seen);
    end
    wait_ack(n);
    total++;
    if (ack !== 4'b0001) begin
      bad++;
      $display("FAIL wd_next: got %b want 0001", ack);
    end
    req = 4'b0;
    wait_rsp(n, seen);
    total++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 16'h0006 || seen !== 4'b0) begin
      bad++;
      $display("FAIL wd_next_rsp: got v %b d %h acks %b want 0001 0006 0000",
               rsp_valid, rsp_data, seen);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    logic stale;
    logic [3:0] seen;
    req = 4'b0001;
    wait_ack(n);
    req = 4'b0;
    repeat (4) step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rmid_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mul_start, busy, ack, rsp_valid, rsp_data, mul_m1} !== '0) begin
      bad++;
      $display("FAIL rmid_clear: got %h want 0",
               {mul_start, busy, ack, rsp_valid, rsp_data, mul_m1});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (15) begin
      step();
      if (rsp_valid !== 4'b0 || busy !== 1'b0) stale = 1'b1;
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL rmid_stale: got stale rsp/busy 1 want 0");
    end
    req = 4'b0100; req_m1[23:16] = 8'h10; req_m2[23:16] = 8'h10;
    wait_ack(n);
    total++;
    if (ack !== 4'b0100) begin
      bad++;
      $display("FAIL rmid_ack: got %b want 0100", ack);
    end
    req = 4'b0;
    wait_rsp(n, seen);
    total++;
    if (n != 11 || rsp_valid !== 4'b0100 || rsp_data !== 16'h0100) begin
      bad++;
      $display("FAIL rmid_rsp: got edges %0d v %b d %h want 11 0100 0100",
               n, rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_boundary();
    int n, hi;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    b_req = 2'b10; b_m1 = 16'h8000; b_m2 = 16'h8000;
    step();
    total++;
    if (b_ack !== 2'b10 || b_mul_start !== 1'b1) begin
      bad++;
      $display("FAIL bnd_accept: got ack %b start %b want 10 1", b_ack, b_mul_start);
    end
    b_req = 2'b0;
    n = 0;
    hi = 1;
    while (b_rsp_valid == 2'b0 && n < 20) begin
      step();
      n++;
      if (b_mul_start) hi++;
    end
    total++;
    if (hi != 3 || n != 4 || b_rsp_valid !== 2'b10 || b_rsp_data !== 16'h4000) begin
      bad++;
      $display("FAIL bnd_rsp: got start %0d edges %0d v %b d %h want 3 4 10 4000",
               hi, n, b_rsp_valid, b_rsp_data);
    end
    step();
    b_req = 2'b01; b_m1 = 16'h0003; b_m2 = 16'h0003;
    step();
    b_req = 2'b0;
    step();
    total++;
    if (b_mul_start !== 1'b1 || b_busy !== 1'b1) begin
      bad++;
      $display("FAIL bnd_in_start: got start %b busy %b want 1 1", b_mul_start, b_busy);
    end
    rst2_n = 1'b0;
    #1;
    total++;
    if ({b_mul_start, b_busy, b_mul_m1} !== 10'b0) begin
      bad++;
      $display("FAIL bnd_async: got %h want 0", {b_mul_start, b_busy, b_mul_m1});
    end
    @(posedge clk); #1;
    rst2_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_contention();
    test_withdraw();
    test_reset_mid();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
